// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and the writeback record
// used by the register file, forwarding logic and writeback arbiter.
package cpu_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_rec_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU result, long-latency handshake,
// register-file write port and FIFO status.
interface wb_arbiter_if #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
);
  import cpu_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic                 alu_valid;
  logic [REG_IDX_W-1:0] alu_rd;
  logic [XLEN-1:0]      alu_data;

  logic                 lu_valid;
  logic                 lu_ready;
  logic [REG_IDX_W-1:0] lu_rd;
  logic [XLEN-1:0]      lu_data;

  logic                 wb_en;
  logic [REG_IDX_W-1:0] rd_index;
  logic [XLEN-1:0]      wb_data;
  logic [CW-1:0]        pending;
  logic                 stall_req;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lu_valid, lu_rd, lu_data,
    output lu_ready,
    output wb_en, rd_index, wb_data,
    output pending, stall_req
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lu_valid, lu_rd, lu_data,
    input  lu_ready,
    input  wb_en, rd_index, wb_data,
    input  pending, stall_req
  );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback records with occupancy count.
// Push is ignored when full, pop is ignored when empty.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  wb_rec_t       i_din,
  input  logic          i_pop,
  output wb_rec_t       o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  wb_rec_t       r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_dout  = r_mem[r_rd];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write port arbiter: ALU results win, queued
// long-latency results retire in the slots the ALU leaves free.
module wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic        clk,
  input  logic        rst,
  wb_arbiter_if.slave bus
);
  import cpu_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic          w_alu_go;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_cnt;
  wb_rec_t       w_din;
  wb_rec_t       w_head;

  logic                 r_wb_en;
  logic [REG_IDX_W-1:0] r_rd;
  logic [XLEN-1:0]      r_data;

  assign w_alu_go = bus.alu_valid && (bus.alu_rd != '0);
  assign w_pop    = !w_alu_go && !w_empty;
  // x0 results complete the handshake but are never queued.
  assign w_push   = bus.lu_valid && !w_full && (bus.lu_rd != '0);
  assign w_din    = '{rd: bus.lu_rd, data: bus.lu_data};

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_en <= 1'b0;
      r_rd    <= '0;
      r_data  <= '0;
    end else begin
      unique case (1'b1)
        w_alu_go: begin
          r_wb_en <= 1'b1;
          r_rd    <= bus.alu_rd;
          r_data  <= bus.alu_data;
        end
        w_pop: begin
          r_wb_en <= 1'b1;
          r_rd    <= w_head.rd;
          r_data  <= w_head.data;
        end
        default: r_wb_en <= 1'b0;
      endcase
    end
  end

  assign bus.lu_ready  = !w_full;
  assign bus.stall_req = w_full;
  assign bus.pending   = w_cnt;
  assign bus.wb_en     = r_wb_en;
  assign bus.rd_index  = r_rd;
  assign bus.wb_data   = r_data;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  wb_arbiter_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

  wb_arbiter #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic        e_en = 1'b0;
  logic [4:0]  e_rd = '0;
  logic [31:0] e_data = '0;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: one write per edge, ALU first, then oldest
  // queued entry; accept only if the queue was not full before the edge.
  always @(posedge clk) begin
    int   pre;
    ent_t e;
    pre = q.size();
    if (rst) begin
      q.delete();
      e_en = 1'b0;
    end else begin
      if (bus.alu_valid && bus.alu_rd != 0) begin
        e_en = 1'b1;
        e_rd = bus.alu_rd;
        e_data = bus.alu_data;
      end else if (pre > 0) begin
        e = q.pop_front();
        e_en = 1'b1;
        e_rd = e.rd;
        e_data = e.d;
      end else begin
        e_en = 1'b0;
      end
      if (bus.lu_valid && pre < DEPTH && bus.lu_rd != 0) begin
        e.rd = bus.lu_rd;
        e.d = bus.lu_data;
        q.push_back(e);
      end
    end
    #1;
    chk("m_wb_en", 32'(bus.wb_en), 32'(e_en));
    if (e_en) begin
      chk("m_rd_index", 32'(bus.rd_index), 32'(e_rd));
      chk("m_wb_data", bus.wb_data, e_data);
    end
    chk("m_pending", 32'(bus.pending), q.size());
    chk("m_lu_ready", 32'(bus.lu_ready), 32'(q.size() < DEPTH));
    chk("m_stall", 32'(bus.stall_req), 32'(q.size() == DEPTH));
  end

  task automatic drv(input logic av, input logic [4:0] ar,
                     input logic [31:0] ad, input logic lv,
                     input logic [4:0] lr, input logic [31:0] ld);
    @(negedge clk);
    bus.alu_valid = av;
    bus.alu_rd    = ar;
    bus.alu_data  = ad;
    bus.lu_valid  = lv;
    bus.lu_rd     = lr;
    bus.lu_data   = ld;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_data  = '0;
    bus.lu_valid  = 1'b0;
    bus.lu_rd     = '0;
    bus.lu_data   = '0;

    #2;
    chk("rst_wb_en", 32'(bus.wb_en), 32'd0);
    chk("rst_rd_index", 32'(bus.rd_index), 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    chk("rst_pending", 32'(bus.pending), 32'd0);
    chk("rst_lu_ready", 32'(bus.lu_ready), 32'd1);
    chk("rst_stall", 32'(bus.stall_req), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // ALU only
    drv(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    settle();
    chk("alu_wb_en", 32'(bus.wb_en), 32'd1);
    chk("alu_rd", 32'(bus.rd_index), 32'd5);
    chk("alu_data", bus.wb_data, 32'hDEADBEEF);
    drv(1'b1, 5'd0, 32'h11111111, 1'b0, 5'd0, 32'd0);
    settle();
    chk("alu_x0_wb_en", 32'(bus.wb_en), 32'd0);

    // Long-latency only: accepted in cycle t, visible at t+2
    drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h12345678);
    settle();
    chk("lu_t1_wb_en", 32'(bus.wb_en), 32'd0);
    chk("lu_t1_pending", 32'(bus.pending), 32'd1);
    idle();
    settle();
    chk("lu_t2_wb_en", 32'(bus.wb_en), 32'd1);
    chk("lu_t2_rd", 32'(bus.rd_index), 32'd7);
    chk("lu_t2_data", bus.wb_data, 32'h12345678);
    chk("lu_t2_pending", 32'(bus.pending), 32'd0);

    // Contention: ALU busy 6 cycles, 4 long-latency results queue up
    for (int i = 0; i < 6; i++) begin
      drv(1'b1, 5'(10 + i), 32'hA0 + i, i < 4, 5'(i + 1), 32'hB0 + i);
      settle();
      if (i == 3) begin
        chk("cont_pending", 32'(bus.pending), 32'd4);
        chk("cont_lu_ready", 32'(bus.lu_ready), 32'd0);
        chk("cont_stall", 32'(bus.stall_req), 32'd1);
      end
    end
    for (int k = 1; k <= 4; k++) begin
      idle();
      settle();
      chk("drain_wb_en", 32'(bus.wb_en), 32'd1);
      chk("drain_rd", 32'(bus.rd_index), k);
      chk("drain_data", bus.wb_data, 32'hB0 + k - 1);
    end
    chk("drain_pending", 32'(bus.pending), 32'd0);

    // Full edge: dequeue and offer in the same cycle, no enqueue
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 5'(20 + i), 32'hC0 + i, 1'b1, 5'(i + 1), 32'hD0 + i);
      settle();
    end
    chk("full_pending", 32'(bus.pending), 32'd4);
    drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hC9);
    settle();
    chk("fe_pending", 32'(bus.pending), 32'd3);
    chk("fe_lu_ready", 32'(bus.lu_ready), 32'd1);
    chk("fe_rd", 32'(bus.rd_index), 32'd1);
    drv(1'b1, 5'd25, 32'hC5, 1'b1, 5'd9, 32'hC9);
    settle();
    chk("fe_refill", 32'(bus.pending), 32'd4);
    for (int k = 0; k < 4; k++) begin
      idle();
      settle();
    end
    chk("fe_last_rd", 32'(bus.rd_index), 32'd9);
    chk("fe_last_data", bus.wb_data, 32'hC9);
    chk("fe_empty", 32'(bus.pending), 32'd0);

    // x0 filtering on the long-latency side
    drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hEE);
    chk("x0_lu_ready", 32'(bus.lu_ready), 32'd1);
    settle();
    chk("x0_pending", 32'(bus.pending), 32'd0);
    idle();
    settle();
    chk("x0_wb_en", 32'(bus.wb_en), 32'd0);

    // Reset mid-operation with three results queued
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 5'(12 + i), 32'hE0 + i, 1'b1, 5'(i + 1), 32'hF0 + i);
      settle();
    end
    chk("mr_pending", 32'(bus.pending), 32'd3);
    @(negedge clk);
    bus.alu_valid = 1'b0;
    bus.lu_valid  = 1'b0;
    #2;
    rst = 1'b1;
    q.delete();
    e_en = 1'b0;
    #1;
    chk("mr_wb_en", 32'(bus.wb_en), 32'd0);
    chk("mr_rd_index", 32'(bus.rd_index), 32'd0);
    chk("mr_wb_data", bus.wb_data, 32'd0);
    chk("mr_pending0", 32'(bus.pending), 32'd0);
    chk("mr_lu_ready", 32'(bus.lu_ready), 32'd1);
    chk("mr_stall", 32'(bus.stall_req), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idle();
      settle();
      chk("mr_no_write", 32'(bus.wb_en), 32'd0);
    end

    // Mixed traffic, including x0 destinations, against the model
    for (int i = 0; i < 80; i++) begin
      drv(($urandom % 3) == 0, 5'($urandom % 8), $urandom,
          ($urandom % 2) == 0, 5'($urandom % 8), $urandom);
    end
    for (int k = 0; k < 8; k++) idle();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter that drives the register file's write port (wb_en / rd_index / wb_data) from two producers: the single-cycle ALU result of the pipeline and a long-latency unit (load/multiply/divide) with a valid/ready handshake. The ALU path always has priority. Long-latency results are queued in a small FIFO and retired in slots the ALU leaves free. Sits between the EX/MEM stages and the register file write port.

## Interface
Parameters:
- DEPTH, 4, long-latency result FIFO entries; power of two, at least 2
- XLEN, 32, data width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- alu_valid  in  1  ALU result present this cycle; never stalled by this block
- alu_rd  in  5  ALU destination index
- alu_data  in  XLEN  ALU result
- lu_valid  in  1  long-latency result offered
- lu_ready  out  1  FIFO can accept; transfer occurs when lu_valid && lu_ready at clock edge
- lu_rd  in  5  long-latency destination index
- lu_data  in  XLEN  long-latency result
- wb_en  out  1  registered write enable to register file
- rd_index  out  5  registered write index
- wb_data  out  XLEN  registered write data
- pending  out  $clog2(DEPTH)+1  FIFO occupancy
- stall_req  out  1  FIFO full; the pipeline must insert an ALU bubble next cycle

## Operation
- Each cycle exactly one write is selected for the next clock edge:
  - ALU first, when alu_valid && alu_rd != 0.
  - Otherwise FIFO head, when the FIFO is non-empty (dequeue).
  - Otherwise none: wb_en <= 0.
- Writes to x0 never reach the port:
  - ALU results with alu_rd == 0 are dropped, and the slot counts as free for the FIFO.
  - Long-latency results with lu_rd == 0 are accepted (handshake completes) but not enqueued.
- lu_ready = !full. It is derived from registered occupancy only, with no combinational path from alu_valid or dequeue. When full, no enqueue occurs even if a dequeue happens the same cycle.
- Simultaneous enqueue and dequeue (non-full, non-empty): occupancy unchanged; head advances; new entry written at tail.
- Enqueue into an empty FIFO with an idle ALU slot: the entry is retired on the next cycle, never the same cycle (no FIFO bypass).
- stall_req = full. The ALU side is expected to deassert alu_valid for one cycle so the head drains.
- Ordering: FIFO entries retire in acceptance order. WAW ordering between the ALU and the long-latency unit is guaranteed by the upstream scoreboard; this block does not check for it.
- Pointers wrap modulo DEPTH. Occupancy ranges 0..DEPTH.

## Timing
- Latency from ALU result to port: 1 cycle (registered outputs).
- Latency from long-latency acceptance to port: at least 2 cycles; +1 for each cycle the ALU occupies the port.
- Reset, asynchronous: wb_en=0, rd_index=0, wb_data=0, pointers=0, pending=0, stall_req=0, lu_ready=1. FIFO contents are don't-care.
- Reset mid-operation: all queued results are discarded immediately. A handshake in the same cycle as rst is lost.
- Throughput: one register write per cycle maximum. The FIFO drains at 1/cycle while alu_valid is low.

## Structure
- Shared package cpu_pkg:
  - XLEN = 32
  - REG_IDX_W = 5
  - writeback record typedef {rd, data}, shared with the register file and forwarding logic
- One sub-module wb_fifo: synchronous FIFO of writeback records, parameter DEPTH, with push/pop/full/empty/count.
- Arbitration and the output register live in wb_arbiter.

## Test plan
- ALU only: alu_valid=1, rd=5, data=0xDEADBEEF → next cycle wb_en=1, rd_index=5, wb_data=0xDEADBEEF; alu_rd=0 → wb_en=0.
- Long-latency only: lu rd=7, data=0x12345678 accepted at cycle t, ALU idle → wb_en=1, rd_index=7 at t+2; pending returns to 0.
- Contention: ALU valid for 6 cycles while 4 lu results (rd=1..4) arrive → pending=4, lu_ready=0, stall_req=1. After ALU goes idle, writes rd=1,2,3,4 appear in order on consecutive cycles.
- Full edge: FIFO full with an ALU bubble (dequeue) and lu_valid high → no enqueue that cycle; lu_ready rises the next cycle; pending=3.
- x0 filtering: lu_rd=0 with lu_valid → handshake completes, pending unchanged, no write issued.
- Reset mid-operation: pending=3, assert rst between clock edges → outputs immediately 0, lu_ready=1. After release, no queued writes appear.
